// File: rtl/keybridge_pkg.sv
// Shared constants, FSM state type and load-source type for the chaos key UART bridge.
package keybridge_pkg;

  localparam logic [7:0] OP_LOAD          = 8'h01;
  localparam logic [7:0] OP_DUMP_KEY_BASE = 8'h10;
  localparam logic [7:0] OP_DUMP_SEEDS    = 8'h20;
  localparam logic [7:0] ACK_BYTE         = 8'hA5;
  localparam logic [7:0] NAK_BYTE         = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StSend
  } state_e;

  typedef enum logic [1:0] {
    SrcKey,
    SrcSeeds,
    SrcAck,
    SrcNak
  } src_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loads a wide vector plus byte count and streams it LSB byte first over valid/ready,
// optionally followed by an XOR-of-sent-bytes trailer.
module byte_serializer #(
  parameter int unsigned MAX_W = 384,
  parameter int unsigned CNT_W = $clog2(MAX_W / 8 + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [MAX_W-1:0] i_data,
  input  logic [CNT_W-1:0] i_nbytes,
  input  logic             i_trailer_en,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_last
);

  logic [MAX_W-1:0] r_shift;
  logic [CNT_W-1:0] r_rem;
  logic             r_trl;
  logic [7:0]       r_xor;
  logic [7:0]       r_byte;
  logic             r_valid;

  logic       w_xfer;
  logic [7:0] w_xor_nxt;

  assign w_xfer    = r_valid & i_ready;
  assign w_xor_nxt = r_xor ^ r_byte;
  assign o_last    = w_xfer && (r_rem == CNT_W'(1)) && !r_trl;
  assign o_valid   = r_valid;
  assign o_data    = r_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_rem   <= '0;
      r_trl   <= 1'b0;
      r_xor   <= 8'h00;
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data >> 8;
      r_byte  <= i_data[7:0];
      r_rem   <= i_nbytes;
      r_trl   <= i_trailer_en;
      r_xor   <= 8'h00;
      r_valid <= (i_nbytes != '0);
    end else if (w_xfer) begin
      r_xor <= w_xor_nxt;
      if (r_rem == CNT_W'(1)) begin
        // The trailer reuses the final count slot, so r_rem stays at 1 for it.
        if (r_trl) begin
          r_byte <= w_xor_nxt;
          r_trl  <= 1'b0;
        end else begin
          r_valid <= 1'b0;
        end
      end else begin
        r_byte  <= r_shift[7:0];
        r_shift <= r_shift >> 8;
        r_rem   <= r_rem - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/chaos_key_uart_bridge.sv
// Opcode-driven UART bridge to the chaos key generator: seed load, start, key/seed dumps.
// Define KEYBRIDGE_CHECKSUM_EN to require a load checksum byte and append dump XOR trailers.
module chaos_key_uart_bridge
  import keybridge_pkg::*;
#(
  parameter int unsigned SEED_W      = 32,
  parameter int unsigned N_SEEDS     = 3,
  parameter int unsigned KEY_W       = 384,
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic [N_SEEDS*SEED_W-1:0] seed_bus,
  output logic                      gen_start,
  input  logic                      gen_done,
  input  logic [N_KEYS*KEY_W-1:0]   key_bus,
  output logic                      busy,
  output logic                      keys_valid,
  output logic                      nak_flag
);

  localparam int unsigned SEEDS_W    = N_SEEDS * SEED_W;
  localparam int unsigned SEED_BYTES = SEEDS_W / 8;
  localparam int unsigned KEY_BYTES  = KEY_W / 8;
  localparam int unsigned MAX_W      = max3(KEY_W, SEEDS_W, 8);
  localparam int unsigned SER_CW     = $clog2(MAX_W / 8 + 1);
  localparam int unsigned BCNT_W     = $clog2(SEED_BYTES + 2);
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYC + 1);
`ifdef KEYBRIDGE_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  state_e              r_state;
  src_e                r_src;
  logic [BCNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]     r_idle;
  logic [SEEDS_W-1:0]  r_shadow;
  logic [SEEDS_W-1:0]  r_seed_bus;
  logic [3:0]          r_key_sel;
  logic                r_gen_start;
  logic                r_keys_valid;
  logic                r_nak;
  logic                r_ld;
`ifdef KEYBRIDGE_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic [SEEDS_W-1:0] w_shadow_wr;
  logic [KEY_W-1:0]   w_key_sel;
  logic [MAX_W-1:0]   w_ld_data;
  logic [SER_CW-1:0]  w_ld_nbytes;
  logic               w_is_dump_key;
  logic               w_key_ok;
  logic               w_last;

  assign w_is_dump_key = (rx_data & 8'hF0) == OP_DUMP_KEY_BASE;
  assign w_key_ok      = {28'd0, rx_data[3:0]} < N_KEYS;

  always_comb begin
    w_shadow_wr = r_shadow;
    for (int j = 0; j < int'(SEED_BYTES); j++) begin
      if (r_cnt == BCNT_W'(j)) w_shadow_wr[8*j +: 8] = rx_data;
    end
  end

  always_comb begin
    w_key_sel = '0;
    for (int k = 0; k < int'(N_KEYS); k++) begin
      if (r_key_sel == 4'(k)) w_key_sel = key_bus[k*KEY_W +: KEY_W];
    end
  end

  // Sampled by the serializer at the end of the SEND entry cycle: that is the snapshot.
  always_comb begin
    w_ld_data   = '0;
    w_ld_nbytes = '0;
    unique case (r_src)
      SrcKey: begin
        w_ld_data[KEY_W-1:0] = w_key_sel;
        w_ld_nbytes          = SER_CW'(KEY_BYTES);
      end
      SrcSeeds: begin
        w_ld_data[SEEDS_W-1:0] = r_seed_bus;
        w_ld_nbytes            = SER_CW'(SEED_BYTES);
      end
      SrcAck: begin
        w_ld_data[7:0] = ACK_BYTE;
        w_ld_nbytes    = SER_CW'(1);
      end
      SrcNak: begin
        w_ld_data[7:0] = NAK_BYTE;
        w_ld_nbytes    = SER_CW'(1);
      end
    endcase
  end

  byte_serializer #(
    .MAX_W (MAX_W),
    .CNT_W (SER_CW)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .i_load       (r_ld),
    .i_data       (w_ld_data),
    .i_nbytes     (w_ld_nbytes),
    .i_trailer_en (CSUM_EN && (r_src == SrcKey || r_src == SrcSeeds)),
    .i_ready      (tx_ready),
    .o_valid      (tx_valid),
    .o_data       (tx_data),
    .o_last       (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_src        <= SrcNak;
      r_cnt        <= '0;
      r_idle       <= '0;
      r_shadow     <= '0;
      r_seed_bus   <= '0;
      r_key_sel    <= 4'd0;
      r_gen_start  <= 1'b0;
      r_keys_valid <= 1'b0;
      r_nak        <= 1'b0;
      r_ld         <= 1'b0;
`ifdef KEYBRIDGE_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_gen_start <= 1'b0;
      r_ld        <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == OP_LOAD) begin
              r_nak    <= 1'b0;
              r_cnt    <= '0;
              r_idle   <= '0;
              r_shadow <= '0;
`ifdef KEYBRIDGE_CHECKSUM_EN
              r_csum   <= 8'h00;
`endif
              r_state  <= StLoad;
            end else if (rx_data == OP_DUMP_SEEDS) begin
              r_nak   <= 1'b0;
              r_src   <= SrcSeeds;
              r_ld    <= 1'b1;
              r_state <= StSend;
            end else if (w_is_dump_key && w_key_ok && r_keys_valid) begin
              r_nak     <= 1'b0;
              r_key_sel <= rx_data[3:0];
              r_src     <= SrcKey;
              r_ld      <= 1'b1;
              r_state   <= StSend;
            end else begin
              r_nak   <= 1'b1;
              r_src   <= SrcNak;
              r_ld    <= 1'b1;
              r_state <= StSend;
            end
          end
        end
        StLoad: begin
          if (rx_valid) begin
            r_idle <= '0;
`ifdef KEYBRIDGE_CHECKSUM_EN
            if (r_cnt == BCNT_W'(SEED_BYTES)) begin
              if (rx_data == r_csum) begin
                r_seed_bus  <= r_shadow;
                r_gen_start <= 1'b1;
                r_state     <= StStart;
              end else begin
                r_shadow <= '0;
                r_nak    <= 1'b1;
                r_src    <= SrcNak;
                r_ld     <= 1'b1;
                r_state  <= StSend;
              end
            end else begin
              r_shadow <= w_shadow_wr;
              r_csum   <= r_csum ^ rx_data;
              r_cnt    <= r_cnt + BCNT_W'(1);
            end
`else
            if (r_cnt == BCNT_W'(SEED_BYTES - 1)) begin
              r_seed_bus  <= w_shadow_wr;
              r_gen_start <= 1'b1;
              r_state     <= StStart;
            end else begin
              r_shadow <= w_shadow_wr;
              r_cnt    <= r_cnt + BCNT_W'(1);
            end
`endif
          end else if (r_idle == TO_W'(TIMEOUT_CYC)) begin
            r_shadow <= '0;
            r_nak    <= 1'b1;
            r_src    <= SrcNak;
            r_ld     <= 1'b1;
            r_state  <= StSend;
          end else begin
            r_idle <= r_idle + TO_W'(1);
          end
        end
        StStart: r_state <= StWait;
        StWait: begin
          if (gen_done) begin
            r_keys_valid <= 1'b1;
            r_src        <= SrcAck;
            r_ld         <= 1'b1;
            r_state      <= StSend;
          end
        end
        StSend: begin
          if (w_last) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign seed_bus   = r_seed_bus;
  assign gen_start  = r_gen_start;
  assign busy       = (r_state != StIdle);
  assign keys_valid = r_keys_valid;
  assign nak_flag   = r_nak;

endmodule

// File: tb/tb_chaos_key_uart_bridge.sv
// Directed scoreboard bench for chaos_key_uart_bridge; KEYBRIDGE_CHECKSUM_EN adds checksum cases.
module tb_chaos_key_uart_bridge;
  import keybridge_pkg::*;

  localparam int unsigned SEED_W      = 32;
  localparam int unsigned N_SEEDS     = 3;
  localparam int unsigned KEY_W       = 384;
  localparam int unsigned N_KEYS      = 4;
  localparam int unsigned TIMEOUT_CYC = 50;
`ifdef KEYBRIDGE_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic                      clk;
  logic                      reset;
  logic                      rx_valid;
  logic [7:0]                rx_data;
  logic                      tx_valid;
  logic [7:0]                tx_data;
  logic                      tx_ready;
  logic [N_SEEDS*SEED_W-1:0] seed_bus;
  logic                      gen_start;
  logic                      gen_done;
  logic [N_KEYS*KEY_W-1:0]   key_bus;
  logic                      busy;
  logic                      keys_valid;
  logic                      nak_flag;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_gen_start = 0;
  int         xfer_cnt = 0;
  bit         rand_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];

  chaos_key_uart_bridge #(
    .SEED_W      (SEED_W),
    .N_SEEDS     (N_SEEDS),
    .KEY_W       (KEY_W),
    .N_KEYS      (N_KEYS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .seed_bus   (seed_bus),
    .gen_start  (gen_start),
    .gen_done   (gen_done),
    .key_bus    (key_bus),
    .busy       (busy),
    .keys_valid (keys_valid),
    .nak_flag   (nak_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] key_byte(int k, int j);
    return 8'(j + 1 + 64 * (k ^ 2));
  endfunction

  function automatic logic [KEY_W-1:0] key_vec(int k);
    logic [KEY_W-1:0] v;
    for (int j = 0; j < int'(KEY_W / 8); j++) v[8*j +: 8] = key_byte(k, j);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_vec(input logic [KEY_W-1:0] v, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v[8*i +: 8]);
      x = x ^ v[8*i +: 8];
    end
`ifdef KEYBRIDGE_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && !tx_valid && exp_q.size() == 0) break;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every accepted byte must be the next expected one; stalled data must hold.
  always @(negedge clk) begin
    if (gen_start) n_gen_start++;
    if (prev_stall && tx_valid) check("tx_hold", tx_data, prev_data);
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready && !reset) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [95:0] s0;
    logic [7:0]  x;
    int          base;
    int          base_x;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    gen_done = 1'b0;
    for (int k = 0; k < int'(N_KEYS); k++) key_bus[k*KEY_W +: KEY_W] = key_vec(k);
    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_seed_bus", seed_bus, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_busy", busy, 0);
    check("rst_keys_valid", keys_valid, 0);
    check("rst_nak_flag", nak_flag, 0);

    // Key dump before any generation is refused; also checks 2-cycle reply latency.
    exp_q.push_back(NAK_BYTE);
    send_rx(8'h10);
    check("lat_decode_tx_valid", tx_valid, 0);
    check("lat_decode_busy", busy, 1);
    tick();
    check("lat_send_tx_valid", tx_valid, 1);
    wait_done("nak_early", 20);
    check("nak_early_flag", nak_flag, 1);

    // Seed load and generation handshake.
    base = n_gen_start;
    send_rx(OP_LOAD);
    check("load_clears_nak", nak_flag, 0);
    x = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      send_rx(8'(i));
      x = x ^ 8'(i);
    end
`ifdef KEYBRIDGE_CHECKSUM_EN
    send_rx(x);
`endif
    check("load_gen_start", gen_start, 1);
    check("load_seed_bus", seed_bus, 96'h0C0B0A09_08070605_04030201);
    tick();
    check("load_gen_start_drop", gen_start, 0);
    check("load_wait_busy", busy, 1);
    repeat (9) tick();
    exp_q.push_back(ACK_BYTE);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    wait_done("ack", 20);
    check("load_one_start", n_gen_start - base, 1);
    check("load_keys_valid", keys_valid, 1);

    // gen_done outside WAIT has no effect.
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick();
    check("stray_done_busy", busy, 0);
    check("stray_done_tx_valid", tx_valid, 0);

    // Out-of-range key index.
    exp_q.push_back(NAK_BYTE);
    send_rx(8'h14);
    wait_done("nak_range", 20);
    check("nak_range_flag", nak_flag, 1);

    // Seed dump returns the committed seeds.
    push_vec({288'd0, 96'h0C0B0A09_08070605_04030201}, 12);
    send_rx(OP_DUMP_SEEDS);
    check("dump_seeds_clears_nak", nak_flag, 0);
    wait_done("dump_seeds", 40);

    // Key 2 with random backpressure; key_bus is disturbed mid-dump to exercise the snapshot.
    base_x = xfer_cnt;
    rand_ready = 1'b1;
    push_vec(key_vec(2), 48);
    send_rx(8'h12);
    repeat (5) tick();
    key_bus = ~key_bus;
    wait_done("dump_key2", 600);
    rand_ready = 1'b0;
    for (int k = 0; k < int'(N_KEYS); k++) key_bus[k*KEY_W +: KEY_W] = key_vec(k);
    check("dump_key2_count", xfer_cnt - base_x, 48 + CSUM);
    tick();

    // Inter-byte timeout during load.
    s0   = seed_bus;
    base = n_gen_start;
    exp_q.push_back(NAK_BYTE);
    send_rx(OP_LOAD);
    for (int i = 0; i < 5; i++) send_rx(8'hF0 + 8'(i));
    wait_done("timeout", 200);
    check("timeout_seed_bus", seed_bus, s0);
    check("timeout_no_start", n_gen_start - base, 0);
    check("timeout_nak_flag", nak_flag, 1);

    // Reset in the middle of a key dump.
    base_x = xfer_cnt;
    push_vec(key_vec(1), 48);
    send_rx(8'h11);
    for (int i = 0; i < 300 && (xfer_cnt - base_x) < 20; i++) @(negedge clk);
    check("reset_reached_byte20", (xfer_cnt - base_x) >= 20, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_tx_valid", tx_valid, 0);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_keys_valid", keys_valid, 0);
    check("reset_mid_seed_bus", seed_bus, 0);
    exp_q.delete();

    base_x = xfer_cnt;
    push_vec('0, 12);
    send_rx(OP_DUMP_SEEDS);
    wait_done("fresh_dump", 40);
    check("fresh_dump_count", xfer_cnt - base_x, 12 + CSUM);

`ifdef KEYBRIDGE_CHECKSUM_EN
    // Bad checksum: no commit, no start.
    base = n_gen_start;
    exp_q.push_back(NAK_BYTE);
    send_rx(OP_LOAD);
    x = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      send_rx(8'(i));
      x = x ^ 8'(i);
    end
    send_rx(x ^ 8'hFF);
    wait_done("bad_csum", 20);
    check("bad_csum_seed_bus", seed_bus, 0);
    check("bad_csum_no_start", n_gen_start - base, 0);
    check("bad_csum_nak_flag", nak_flag, 1);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chaos_key_uart_bridge.md
# chaos_key_uart_bridge

Parametrised command-driven bridge between the UART byte links and the chaos key generator (`combined_system`). It receives seed words over UART, commits them to the generator atomically, and pulses the start. It then streams any selected key or the current seeds back over UART with a valid/ready handshake. It replaces hard-wired select inputs and fixed 48-byte framing with an opcode protocol, generic widths and counts, error replies and an inter-byte timeout.

## Interface
- `SEED_W`, 32: bits per seed word; multiple of 8.
- `N_SEEDS`, 3: number of seed words (x, y, z).
- `KEY_W`, 384: bits per key; multiple of 8.
- `N_KEYS`, 4: number of keys from the generator; at most 16.
- `TIMEOUT_CYC`, 1_000_000: maximum idle cycles between bytes during seed load.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: `tx_data` is offered to the transmitter.
- `tx_data` out 8: byte to send.
- `tx_ready` in 1: transmitter accepts; transfer happens when `tx_valid && tx_ready`.
- `seed_bus` out N_SEEDS*SEED_W: committed seeds, seed 0 in the LSBs.
- `gen_start` out 1: one-cycle start pulse to the generator.
- `gen_done` in 1: one-cycle completion pulse from the generator.
- `key_bus` in N_KEYS*KEY_W: all keys, key 0 in the LSBs.
- `busy` out 1: FSM not in IDLE.
- `keys_valid` out 1: a generation has completed since reset.
- `nak_flag` out 1: sticky; set on any NAK and cleared by the next accepted opcode.

## Operation
- The FSM has states IDLE, LOAD, START, WAIT, SEND.
- All multi-byte fields are little-endian: byte j maps to bits [8j +: 8].
- IDLE: an `rx_valid` byte is an opcode.
  - 0x01 (LOAD_SEEDS): clear the byte counter and go to LOAD.
  - 0x10+k, k<N_KEYS (DUMP_KEY): if `keys_valid`, snapshot key k and go to SEND with KEY_W/8 bytes; otherwise NAK.
  - 0x20 (DUMP_SEEDS): snapshot `seed_bus` and go to SEND with N_SEEDS*SEED_W/8 bytes.
  - Any other opcode, including 0x10+k with k≥N_KEYS: NAK.
- LOAD:
  - Each byte goes into a shadow register at the byte-counter position.
  - After byte SEED_BYTES-1 (SEED_BYTES = N_SEEDS*SEED_W/8), go to START.
  - If the idle counter reaches TIMEOUT_CYC with no `rx_valid`, discard the shadow register, NAK, and return to IDLE.
- START: lasts one cycle. Copy the shadow register to `seed_bus`, assert `gen_start`, go to WAIT.
- WAIT: on `gen_done`, set `keys_valid` and send ACK 0xA5 through SEND (1 byte).
- SEND:
  - Bytes come from the snapshot, LSB byte first.
  - Return to IDLE on the cycle the last byte transfers.
- NAK: send the single byte 0xEE through SEND and set `nak_flag`.
- `rx_valid` in START, WAIT or SEND is dropped without effect.
- The snapshot is taken on the entry cycle of SEND. Later changes on `key_bus` or `seed_bus` do not alter a dump in progress.

## Timing
- Reset values:
  - Outputs: `tx_valid`=0, `tx_data`=0, `seed_bus`=0, `gen_start`=0, `busy`=0, `keys_valid`=0, `nak_flag`=0.
  - Internal: state IDLE, all counters 0.
- Latencies:
  - Opcode strobe to first `tx_valid` is 2 cycles (decode, then SEND).
  - `gen_start` asserts 1 cycle after the final seed-byte strobe, concurrent with the `seed_bus` update.
- WAIT is entered the cycle after `gen_start`. `gen_done` is sampled only in WAIT and ignored in every other state.
- Handshake: `tx_data` stays stable while `tx_valid && !tx_ready`. `tx_valid` may stay high across consecutive bytes, so throughput is 1 byte per cycle when `tx_ready` is held at 1.
- The timeout counter resets on every `rx_valid` in LOAD. Timeout fires on the cycle the count equals TIMEOUT_CYC.
- `reset` mid-transfer: the FSM aborts immediately. There is no partial commit to `seed_bus`, and `tx_valid` drops the next cycle.

## Configuration
- `KEYBRIDGE_CHECKSUM_EN` defined:
  - LOAD expects one extra byte equal to the XOR of all seed bytes. On mismatch: NAK, no commit, no `gen_start`.
  - Every dump appends one trailer byte equal to the XOR of the sent bytes. The ACK and NAK single-byte replies get no trailer.
- Undefined: no checksum byte is expected or sent, and LOAD ends after SEED_BYTES bytes.

## Structure
- Package `keybridge_pkg` holds:
  - opcode constants OP_LOAD=0x01, OP_DUMP_KEY_BASE=0x10, OP_DUMP_SEEDS=0x20;
  - ACK_BYTE=0xA5 and NAK_BYTE=0xEE;
  - the FSM state enum.
- Sub-module `byte_serializer`, parametrised by maximum width:
  - loads a wide vector and a byte count;
  - presents bytes LSB first on valid/ready;
  - pulses `last` on the final transfer;
  - optionally appends the XOR trailer.

## Test plan
- LOAD_SEEDS with bytes 01 02 03 04 05 06 07 08 09 0A 0B 0C, then `gen_done` pulsed 10 cycles later:
  - `seed_bus`={0x0C0B0A09, 0x08070605, 0x04030201} (z, y, x);
  - exactly one `gen_start` pulse;
  - `tx_data`=0xA5;
  - `keys_valid`=1.
- DUMP_KEY 0x12 after generation with key 2 = 384'h…0201: 48 bytes sent, first 0x01, second 0x02; `tx_ready` toggled randomly yields no loss or duplication.
- DUMP_KEY before any generation, and opcode 0x14 with N_KEYS=4: each returns single byte 0xEE and sets `nak_flag`.
- LOAD_SEEDS, 5 bytes, then silence for TIMEOUT_CYC (set to 50): 0xEE is sent, `seed_bus` is unchanged and no `gen_start` occurs.
- `reset` asserted at byte 20 of a key dump: `tx_valid`=0 and `busy`=0 next cycle; a fresh DUMP_SEEDS then returns 12 bytes.
- With `KEYBRIDGE_CHECKSUM_EN`:
  - wrong checksum on LOAD gives 0xEE and no commit;
  - DUMP_SEEDS returns 13 bytes with the last byte equal to the XOR of the first 12.
